// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light controller and its monitor:
// phase encoding, default phase durations and light-vector helpers.
package traffic_pkg;

  // Tracked phase encoding (also the value presented on the phase output).
  localparam logic [1:0] PhGreen  = 2'd0;
  localparam logic [1:0] PhOrange = 2'd1;
  localparam logic [1:0] PhRed    = 2'd2;
  localparam logic [1:0] PhUnsync = 2'd3;

  // Default phase lengths in clock cycles, shared with the controller.
  localparam int unsigned GreenCyclesDef  = 21;
  localparam int unsigned OrangeCyclesDef = 6;
  localparam int unsigned RedCyclesDef    = 11;

  typedef struct packed {
    logic g;
    logic o;
    logic r;
  } lights_t;

  // Legal successor of a phase; UNSYNC has no successor.
  function automatic logic [1:0] next_phase(input logic [1:0] ph);
    logic [1:0] nxt;
    case (ph)
      PhGreen:  nxt = PhOrange;
      PhOrange: nxt = PhRed;
      PhRed:    nxt = PhGreen;
      default:  nxt = PhUnsync;
    endcase
    return nxt;
  endfunction

  // Phase indicated by a light vector; only meaningful when it is one-hot.
  function automatic logic [1:0] light_phase(input lights_t l);
    logic [1:0] ph;
    if (l.g) begin
      ph = PhGreen;
    end else if (l.o) begin
      ph = PhOrange;
    end else begin
      ph = PhRed;
    end
    return ph;
  endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// Light inputs and checker status outputs of the traffic light monitor.
// master: the side that drives the lights and watches the status.
// slave:  the monitor itself.
interface traffic_light_monitor_if #(
  parameter int unsigned NW = 16
);

  logic          g_light;
  logic          o_light;
  logic          r_light;
  logic [1:0]    phase;
  logic          err_onehot;
  logic          err_order;
  logic          err_timing;
  logic          err_sticky;
  logic [NW-1:0] cycles_done;

  modport master (
    output g_light, o_light, r_light,
    input  phase, err_onehot, err_order, err_timing, err_sticky, cycles_done
  );

  modport slave (
    input  g_light, o_light, r_light,
    output phase, err_onehot, err_order, err_timing, err_sticky, cycles_done
  );

endinterface

// File: rtl/phase_timer.sv
// Saturating phase duration counter. Loads 1 on phase entry, increments
// while the phase holds, compares against the programmed length and raises
// a once-per-phase overrun pulse when the phase outlives that length.
module phase_timer #(
  parameter int unsigned CW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          load,
  input  logic          inc,
  input  logic          arm,
  input  logic [CW-1:0] expected,
  output logic          on_time,
  output logic          overrun,
  output logic          overrun_seen
);

  localparam logic [CW-1:0] DurMax = '1;

  logic [CW-1:0] dur_q, dur_d;
  logic          seen_q, seen_d;

  assign on_time      = (dur_q == expected);
  // Incrementing past exactly the expected count means dur becomes expected+1.
  assign overrun      = inc && arm && on_time && !seen_q;
  assign overrun_seen = seen_q;

  // Next duration and overrun-flag state.
  always_comb begin
    dur_d  = dur_q;
    seen_d = seen_q;
    if (clear) begin
      dur_d  = '0;
      seen_d = 1'b0;
    end else if (load) begin
      dur_d  = CW'(1);
      seen_d = 1'b0;
    end else if (inc) begin
      if (dur_q != DurMax) begin
        dur_d = dur_q + 1'b1;
      end
      if (overrun) begin
        seen_d = 1'b1;
      end
    end
  end

  // Duration and overrun-flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      dur_q  <= '0;
      seen_q <= 1'b0;
    end else begin
      dur_q  <= dur_d;
      seen_q <= seen_d;
    end
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker for the green/orange/red light outputs of the traffic
// light controller: one-hot, phase order and phase duration checks, with
// registered error pulses, a sticky error flag and a completed-cycle count.
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter int unsigned G_CYCLES = GreenCyclesDef,
  parameter int unsigned O_CYCLES = OrangeCyclesDef,
  parameter int unsigned R_CYCLES = RedCyclesDef,
  parameter int unsigned CW       = 10,
  parameter int unsigned NW       = 16
) (
  input logic                    clk,
  input logic                    rst,
  traffic_light_monitor_if.slave bus
);

  localparam int unsigned MaxGo     = (G_CYCLES > O_CYCLES) ? G_CYCLES : O_CYCLES;
  localparam int unsigned MaxCycles = (MaxGo > R_CYCLES) ? MaxGo : R_CYCLES;
  localparam longint unsigned DurMax = (64'd1 << CW) - 64'd1;

  // The counter must reach expected+1 to detect an overrun before saturating.
  if (DurMax < 64'(MaxCycles) + 64'd1) begin : g_cw_check
    $error("traffic_light_monitor: CW too narrow for the longest phase");
  end

  lights_t    lights;
  logic       one_hot;
  logic [1:0] light_ph;

  assign lights   = {bus.g_light, bus.o_light, bus.r_light};
  assign one_hot  = $onehot(lights);
  assign light_ph = light_phase(lights);

  logic [1:0]    phase_q, phase_d;
  logic          timing_ok_q, timing_ok_d;
  logic          g_ok_q, g_ok_d;
  logic          o_ok_q, o_ok_d;
  logic [NW-1:0] cycles_q, cycles_d;
  logic          err_onehot_q, err_onehot_d;
  logic          err_order_q, err_order_d;
  logic          err_timing_q, err_timing_d;
  logic          err_sticky_q, err_sticky_d;

  logic          same_phase;
  logic          legal;
  logic          leaving_good;
  logic [CW-1:0] expected;
  logic          on_time;
  logic          overrun;
  logic          overrun_seen;

  // Programmed length of the phase currently being tracked.
  always_comb begin
    case (phase_q)
      PhGreen:  expected = CW'(G_CYCLES);
      PhOrange: expected = CW'(O_CYCLES);
      PhRed:    expected = CW'(R_CYCLES);
      default:  expected = '0;
    endcase
  end

  assign same_phase   = one_hot && (phase_q != PhUnsync) && (light_ph == phase_q);
  assign legal        = (light_ph == next_phase(phase_q));
  assign leaving_good = timing_ok_q && on_time;

  phase_timer #(
    .CW(CW)
  ) u_phase_timer (
    .clk          (clk),
    .rst          (rst),
    .clear        (!one_hot),
    .load         (one_hot && !same_phase),
    .inc          (same_phase),
    .arm          (timing_ok_q),
    .expected     (expected),
    .on_time      (on_time),
    .overrun      (overrun),
    .overrun_seen (overrun_seen)
  );

  // Phase tracking, error decode and cycle accounting.
  always_comb begin
    phase_d      = phase_q;
    timing_ok_d  = timing_ok_q;
    g_ok_d       = g_ok_q;
    o_ok_d       = o_ok_q;
    cycles_d     = cycles_q;
    err_onehot_d = 1'b0;
    err_order_d  = 1'b0;
    err_timing_d = 1'b0;

    if (!one_hot) begin
      err_onehot_d = 1'b1;
      phase_d      = PhUnsync;
      timing_ok_d  = 1'b0;
      g_ok_d       = 1'b0;
      o_ok_d       = 1'b0;
    end else if (phase_q == PhUnsync) begin
      // First phase after sync has an unknown start, so it is not timed.
      phase_d     = light_ph;
      timing_ok_d = 1'b0;
    end else if (same_phase) begin
      err_timing_d = overrun;
    end else begin
      phase_d = light_ph;
      if (legal) begin
        timing_ok_d  = 1'b1;
        // An overrun was already reported inside the phase; do not repeat it.
        err_timing_d = timing_ok_q && !on_time && !overrun_seen;
        case (phase_q)
          PhGreen:  g_ok_d = leaving_good;
          PhOrange: o_ok_d = leaving_good;
          PhRed: begin
            if (leaving_good && g_ok_q && o_ok_q) begin
              cycles_d = cycles_q + 1'b1;
            end
          end
          default: ;
        endcase
      end else begin
        err_order_d = 1'b1;
        timing_ok_d = 1'b0;
        g_ok_d      = 1'b0;
        o_ok_d      = 1'b0;
      end
    end

    err_sticky_d = err_sticky_q | err_onehot_d | err_order_d | err_timing_d;
  end

  // State and registered outputs; reset also drops any pending pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q      <= PhUnsync;
      timing_ok_q  <= 1'b0;
      g_ok_q       <= 1'b0;
      o_ok_q       <= 1'b0;
      cycles_q     <= '0;
      err_onehot_q <= 1'b0;
      err_order_q  <= 1'b0;
      err_timing_q <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      timing_ok_q  <= timing_ok_d;
      g_ok_q       <= g_ok_d;
      o_ok_q       <= o_ok_d;
      cycles_q     <= cycles_d;
      err_onehot_q <= err_onehot_d;
      err_order_q  <= err_order_d;
      err_timing_q <= err_timing_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign bus.phase       = phase_q;
  assign bus.err_onehot  = err_onehot_q;
  assign bus.err_order   = err_order_q;
  assign bus.err_timing  = err_timing_q;
  assign bus.err_sticky  = err_sticky_q;
  assign bus.cycles_done = cycles_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: every driven cycle pushes the model's
// expected outputs, every sampled cycle pushes the observed outputs, and each
// scenario task drains and compares both queues plus its own targeted checks.
module tb_traffic_light_monitor;
  import traffic_pkg::*;

  localparam int unsigned GC = 21;
  localparam int unsigned OC = 6;
  localparam int unsigned RC = 11;
  localparam int unsigned CW = 10;
  localparam int unsigned NW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  traffic_light_monitor_if #(.NW(NW)) bus ();

  traffic_light_monitor #(
    .G_CYCLES (GC),
    .O_CYCLES (OC),
    .R_CYCLES (RC),
    .CW       (CW),
    .NW       (NW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    phase;
    logic          eo;
    logic          eord;
    logic          et;
    logic          es;
    logic [NW-1:0] cd;
  } out_t;

  out_t exp_q[$];
  out_t obs_q[$];
  out_t last_obs;
  int   n_checks = 0;
  int   n_errs   = 0;

  // Reference model state
  int m_phase = 3;
  int m_dur   = 0;
  int m_cd    = 0;
  bit m_tok, m_seen, m_gok, m_ook, m_sticky;

  task automatic model_cycle(input bit g, input bit o, input bit r, input bit rs);
    out_t e;
    int   lp;
    int   ex;
    bit   legal;
    bit   good;
    e = '0;
    if (rs) begin
      m_phase = 3; m_dur = 0; m_tok = 0; m_seen = 0; m_gok = 0; m_ook = 0;
      m_sticky = 0; m_cd = 0;
    end else if (int'(g) + int'(o) + int'(r) != 1) begin
      e.eo = 1'b1;
      m_phase = 3; m_dur = 0; m_tok = 0; m_seen = 0; m_gok = 0; m_ook = 0;
    end else begin
      lp = g ? 0 : (o ? 1 : 2);
      ex = (m_phase == 0) ? GC : ((m_phase == 1) ? OC : RC);
      if (m_phase == 3) begin
        m_phase = lp; m_dur = 1; m_tok = 0; m_seen = 0;
      end else if (lp == m_phase) begin
        if (m_dur < 1023) m_dur++;
        if (m_tok && m_dur == ex + 1 && !m_seen) begin
          e.et = 1'b1;
          m_seen = 1;
        end
      end else begin
        legal = (lp == (m_phase + 1) % 3);
        good  = m_tok && (m_dur == ex);
        if (legal) begin
          if (m_tok && m_dur != ex && !m_seen) e.et = 1'b1;
          if (m_phase == 0) m_gok = good;
          else if (m_phase == 1) m_ook = good;
          else if (good && m_gok && m_ook) m_cd = (m_cd + 1) % 65536;
          m_tok = 1;
        end else begin
          e.eord = 1'b1;
          m_tok = 0; m_gok = 0; m_ook = 0;
        end
        m_phase = lp; m_dur = 1; m_seen = 0;
      end
    end
    m_sticky = !rs && (m_sticky || e.eo || e.eord || e.et);
    e.phase = 2'(m_phase);
    e.es    = m_sticky;
    e.cd    = NW'(m_cd);
    exp_q.push_back(e);
  endtask

  // One clock cycle: drive on the falling edge, sample 1 ns after the rising edge.
  task automatic step(input bit g, input bit o, input bit r, input bit rs);
    @(negedge clk);
    bus.g_light = g;
    bus.o_light = o;
    bus.r_light = r;
    rst         = rs;
    model_cycle(g, o, r, rs);
    @(posedge clk);
    #1;
    last_obs.phase = bus.phase;
    last_obs.eo    = bus.err_onehot;
    last_obs.eord  = bus.err_order;
    last_obs.et    = bus.err_timing;
    last_obs.es    = bus.err_sticky;
    last_obs.cd    = bus.cycles_done;
    obs_q.push_back(last_obs);
  endtask

  task automatic run(input logic [2:0] v, input int n);
    for (int i = 0; i < n; i++) step(v[2], v[1], v[0], 1'b0);
  endtask

  task automatic test_reset;
    out_t e, o;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (last_obs.phase !== 2'd3) begin
      n_errs++; $display("FAIL reset_phase: got %0d expected 3", last_obs.phase);
    end
    n_checks++;
    if (last_obs.cd !== '0 || last_obs.es !== 1'b0) begin
      n_errs++; $display("FAIL reset_counts: got cd=%0d es=%0b expected 0/0", last_obs.cd, last_obs.es);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin
        n_errs++;
        $display("FAIL reset_cycle: got %h expected %h", o, e);
      end
    end
  endtask

  task automatic test_clean;
    out_t e, o;
    int n_e = 0;
    for (int k = 0; k < 3; k++) begin
      run(3'b100, GC); run(3'b010, OC); run(3'b001, RC);
    end
    run(3'b100, 1);  // completes the third red
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      n_e += int'(o.eo) + int'(o.eord) + int'(o.et);
      if (o !== e) begin
        n_errs++;
        $display("FAIL clean_cycle: got %h expected %h", o, e);
      end
    end
    n_checks++;
    if (n_e != 0) begin
      n_errs++; $display("FAIL clean_no_errors: got %0d pulses expected 0", n_e);
    end
    n_checks++;
    if (last_obs.cd !== NW'(2)) begin
      n_errs++; $display("FAIL clean_cycles_done: got %0d expected 2", last_obs.cd);
    end
  endtask

  task automatic test_short_red;
    out_t e, o;
    int n_et = 0;
    run(3'b100, GC - 1); run(3'b010, OC); run(3'b001, RC - 1); run(3'b100, 1);
    n_checks++;
    if (last_obs.et !== 1'b1) begin
      n_errs++; $display("FAIL short_red_pulse: got %0b expected 1", last_obs.et);
    end
    n_checks++;
    if (last_obs.cd !== NW'(2)) begin
      n_errs++; $display("FAIL short_red_count: got %0d expected 2", last_obs.cd);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      n_et += int'(o.et);
      if (o !== e) begin
        n_errs++;
        $display("FAIL short_red_cycle: got %h expected %h", o, e);
      end
    end
    n_checks++;
    if (n_et != 1) begin
      n_errs++; $display("FAIL short_red_single: got %0d pulses expected 1", n_et);
    end
  endtask

  task automatic test_order;
    out_t e, o;
    int n_et = 0;
    int n_or = 0;
    run(3'b100, GC - 1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (last_obs.eord !== 1'b1 || last_obs.phase !== 2'd2 || last_obs.et !== 1'b0) begin
      n_errs++;
      $display("FAIL order_jump: got eord=%0b phase=%0d et=%0b expected 1/2/0",
               last_obs.eord, last_obs.phase, last_obs.et);
    end
    run(3'b001, RC - 1); run(3'b100, GC); run(3'b010, OC); run(3'b001, RC); run(3'b100, 1);
    n_checks++;
    if (last_obs.cd !== NW'(3)) begin
      n_errs++; $display("FAIL order_recount: got %0d expected 3", last_obs.cd);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      n_et += int'(o.et); n_or += int'(o.eord);
      if (o !== e) begin
        n_errs++;
        $display("FAIL order_cycle: got %h expected %h", o, e);
      end
    end
    n_checks++;
    if (n_or != 1 || n_et != 0) begin
      n_errs++; $display("FAIL order_pulses: got order=%0d timing=%0d expected 1/0", n_or, n_et);
    end
  endtask

  task automatic test_overrun;
    out_t e, o;
    int n_et = 0;
    // Green entered with one cycle already; 24 more make 25.
    for (int i = 0; i < 24; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      if (i == 20) begin
        n_checks++;
        if (last_obs.et !== 1'b1) begin
          n_errs++; $display("FAIL overrun_at_22: got %0b expected 1", last_obs.et);
        end
      end
    end
    run(3'b010, OC); run(3'b001, RC); run(3'b100, 1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      n_et += int'(o.et);
      if (o !== e) begin
        n_errs++;
        $display("FAIL overrun_cycle: got %h expected %h", o, e);
      end
    end
    n_checks++;
    if (n_et != 1 || last_obs.cd !== NW'(3)) begin
      n_errs++; $display("FAIL overrun_once: got %0d pulses cd=%0d expected 1/3", n_et, last_obs.cd);
    end
  endtask

  task automatic test_onehot;
    out_t e, o;
    int n_eo = 0;
    int n_other = 0;
    run(3'b100, GC - 1); run(3'b010, 3);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (last_obs.eo !== 1'b1 || last_obs.phase !== 2'd3 || last_obs.es !== 1'b1) begin
      n_errs++;
      $display("FAIL onehot_pulse: got eo=%0b phase=%0d es=%0b expected 1/3/1",
               last_obs.eo, last_obs.phase, last_obs.es);
    end
    run(3'b010, 3);
    n_checks++;
    if (last_obs.phase !== 2'd1) begin
      n_errs++; $display("FAIL onehot_resync: got %0d expected 1", last_obs.phase);
    end
    run(3'b001, RC); run(3'b100, 1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      n_eo += int'(o.eo); n_other += int'(o.et) + int'(o.eord);
      if (o !== e) begin
        n_errs++;
        $display("FAIL onehot_cycle: got %h expected %h", o, e);
      end
    end
    n_checks++;
    if (n_eo != 1 || n_other != 0 || last_obs.cd !== NW'(3)) begin
      n_errs++;
      $display("FAIL onehot_summary: got eo=%0d other=%0d cd=%0d expected 1/0/3",
               n_eo, n_other, last_obs.cd);
    end
  endtask

  task automatic test_reset_mid;
    out_t e, o;
    run(3'b100, GC - 1); run(3'b010, OC); run(3'b001, 5);
    n_checks++;
    if (last_obs.es !== 1'b1 || last_obs.cd !== NW'(3)) begin
      n_errs++; $display("FAIL pre_reset: got es=%0b cd=%0d expected 1/3", last_obs.es, last_obs.cd);
    end
    step(1'b0, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (last_obs.phase !== 2'd3 || last_obs.cd !== '0 || last_obs.es !== 1'b0) begin
      n_errs++;
      $display("FAIL mid_reset: got phase=%0d cd=%0d es=%0b expected 3/0/0",
               last_obs.phase, last_obs.cd, last_obs.es);
    end
    run(3'b001, 2);
    n_checks++;
    if (last_obs.phase !== 2'd2 || last_obs.es !== 1'b0) begin
      n_errs++; $display("FAIL post_reset: got phase=%0d es=%0b expected 2/0", last_obs.phase, last_obs.es);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin
        n_errs++;
        $display("FAIL reset_mid_cycle: got %h expected %h", o, e);
      end
    end
  endtask

  initial begin
    bus.g_light = 1'b0;
    bus.o_light = 1'b0;
    bus.r_light = 1'b0;
    test_reset();
    test_clean();
    test_short_red();
    test_order();
    test_overrun();
    test_onehot();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
